// File: rtl/switch_out_arbiter_pkg.sv
// Shared switch types: port count, port masks/indices and payload word width.
// Pure declarations. No logic and no latency.
// Optional feature macro used by importers: ARB_WATCHDOG_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package switch_out_arbiter_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int DATA_WIDTH = `DATA_WIDTH;

  typedef logic [NUM_PORTS-1:0]  port_mask_t;
  typedef logic [1:0]            port_idx_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [3:0]            idle_cnt_t;

  // The idle counter value that, incremented once more, reaches 15 and forces release.
  localparam idle_cnt_t IDLE_LAST = idle_cnt_t'(14);

endpackage

// File: rtl/switch_out_arbiter_if.sv
// Request/grant and crossbar bus between the input controllers and the output arbiter.
// Wires only, so no latency. Flow control is the req/gnt handshake, with no per-word stall.
// Macro ARB_WATCHDOG_EN adds the per-input timeout pulse.
interface switch_out_arbiter_if;
  import switch_out_arbiter_pkg::*;

  logic [NUM_PORTS-1:0]            req;
  logic [NUM_PORTS*NUM_PORTS-1:0]  req_mask;
  logic [NUM_PORTS-1:0]            in_valid;
  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0]            gnt;
  logic [NUM_PORTS-1:0]            out_valid;
  logic [NUM_PORTS*DATA_WIDTH-1:0] out_data;
  logic [NUM_PORTS-1:0]            out_busy;
  logic [NUM_PORTS-1:0]            mask_err;
`ifdef ARB_WATCHDOG_EN
  logic [NUM_PORTS-1:0]            timeout;

  modport master (
    output req, req_mask, in_valid, in_data,
    input  gnt, out_valid, out_data, out_busy, mask_err, timeout
  );
  modport slave (
    input  req, req_mask, in_valid, in_data,
    output gnt, out_valid, out_data, out_busy, mask_err, timeout
  );
`else
  modport master (
    output req, req_mask, in_valid, in_data,
    input  gnt, out_valid, out_data, out_busy, mask_err
  );
  modport slave (
    input  req, req_mask, in_valid, in_data,
    output gnt, out_valid, out_data, out_busy, mask_err
  );
`endif

endinterface

// File: rtl/switch_out_arbiter_rr_mask_alloc.sv
// Round-robin whole-mask allocator. Grants each request only if all of its outputs are free.
// Combinational, with zero latency.
// A request that does not fit simply waits. It has no partial grant and does not block later inputs.
module rr_mask_alloc
  import switch_out_arbiter_pkg::*;
(
  input  port_mask_t                  req,
  input  port_mask_t [NUM_PORTS-1:0]  masks,
  input  port_mask_t                  free,
  input  port_idx_t                   rr_ptr,
  output port_mask_t                  grant,
  output port_mask_t                  own_set,
  output port_idx_t  [NUM_PORTS-1:0]  own_idx,
  output port_idx_t                   rr_ptr_nxt
);

  port_mask_t free_v;
  port_idx_t  idx;

  // Scan from rr_ptr, granting each fitting mask and shrinking the free set as grants land.
  always_comb begin
    free_v     = free;
    idx        = '0;
    grant      = '0;
    own_set    = '0;
    own_idx    = '0;
    rr_ptr_nxt = rr_ptr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = rr_ptr + port_idx_t'(k);
      if (req[idx] && (masks[idx] != '0) && ((masks[idx] & ~free_v) == '0)) begin
        grant[idx] = 1'b1;
        own_set    = own_set | masks[idx];
        for (int o = 0; o < NUM_PORTS; o++) begin
          if (masks[idx][o]) own_idx[o] = idx;
        end
        free_v     = free_v & ~masks[idx];
        rr_ptr_nxt = idx + port_idx_t'(1);
      end
    end
  end

endmodule

// File: rtl/switch_out_arbiter.sv
// Output allocator and crossbar. Holds the owner table, round-robin pointer and registered datapath.
// Latency: grant 1 cycle after req, and words 1 cycle from input to output. Freed outputs idle 1 cycle.
// No per-word backpressure. An input waits on gnt. Macro ARB_WATCHDOG_EN enables idle-release timeout.
module switch_out_arbiter
  import switch_out_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  switch_out_arbiter_if.slave  bus
);

  port_mask_t                 masks [NUM_PORTS];
  port_mask_t [NUM_PORTS-1:0] masks_p;
  data_t      [NUM_PORTS-1:0] in_dat;

  port_mask_t                 own_vld_q, own_vld_d;
  port_idx_t  [NUM_PORTS-1:0] own_idx_q, own_idx_d;
  port_mask_t                 gnt_q, gnt_d;
  port_idx_t                  rr_ptr_q, rr_ptr_d;
  port_mask_t                 out_valid_q, out_valid_d;
  data_t      [NUM_PORTS-1:0] out_data_q, out_data_d;
  port_mask_t                 req_seen_q, req_seen_d;
  port_mask_t                 mask_err_q, mask_err_d;
  port_mask_t                 force_rel;

  port_mask_t                 alloc_req, alloc_grant, alloc_own_set;
  port_idx_t  [NUM_PORTS-1:0] alloc_own_idx;
  port_idx_t                  alloc_rr_nxt;

  assign masks_p = bus.req_mask;
  assign in_dat  = bus.in_data;
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_mask
    assign masks[g] = masks_p[g];
  end

`ifdef ARB_WATCHDOG_EN
  idle_cnt_t [NUM_PORTS-1:0] idle_cnt_q, idle_cnt_d;
  port_mask_t                wd_block_q, wd_block_d;
  port_mask_t                timeout_q, timeout_d;

  // Count idle cycles of a granted input. Force release at 15, and block regrant until req toggles.
  always_comb begin
    force_rel  = '0;
    timeout_d  = '0;
    idle_cnt_d = idle_cnt_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_q[i] && !bus.in_valid[i]) begin
        if (idle_cnt_q[i] == IDLE_LAST) begin
          force_rel[i]  = 1'b1;
          timeout_d[i]  = 1'b1;
          idle_cnt_d[i] = '0;
        end else begin
          idle_cnt_d[i] = idle_cnt_q[i] + idle_cnt_t'(1);
        end
      end else begin
        idle_cnt_d[i] = '0;
      end
    end
    wd_block_d = bus.req & (wd_block_q | force_rel);
  end

  assign alloc_req   = bus.req & ~gnt_q & ~wd_block_q;
  assign bus.timeout = timeout_q;
`else
  assign force_rel = '0;
  assign alloc_req = bus.req & ~gnt_q;
`endif

  // Free set comes from registered ownership, so outputs released this edge sit out one cycle.
  rr_mask_alloc u_alloc (
    .req        (alloc_req),
    .masks      (masks_p),
    .free       (~own_vld_q),
    .rr_ptr     (rr_ptr_q),
    .grant      (alloc_grant),
    .own_set    (alloc_own_set),
    .own_idx    (alloc_own_idx),
    .rr_ptr_nxt (alloc_rr_nxt)
  );

  // Owner table update: release on req drop or watchdog, then apply this cycle's grants.
  always_comb begin
    own_vld_d = own_vld_q;
    own_idx_d = own_idx_q;
    gnt_d     = gnt_q & bus.req & ~force_rel;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (own_vld_q[o] && (!bus.req[own_idx_q[o]] || force_rel[own_idx_q[o]])) begin
        own_vld_d[o] = 1'b0;
      end
      if (alloc_own_set[o]) begin
        own_vld_d[o] = 1'b1;
        own_idx_d[o] = alloc_own_idx[o];
      end
    end
    gnt_d    = gnt_d | alloc_grant;
    rr_ptr_d = alloc_rr_nxt;
  end

  // Crossbar: owned outputs copy their owner's word. Unowned outputs drop valid and hold data.
  always_comb begin
    out_valid_d = '0;
    out_data_d  = out_data_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (own_vld_q[o]) begin
        out_valid_d[o] = bus.in_valid[own_idx_q[o]];
        out_data_d[o]  = in_dat[own_idx_q[o]];
      end
    end
  end

  // Zero-mask error pulses once per request, on the first cycle that req is seen.
  always_comb begin
    req_seen_d = bus.req;
    mask_err_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      mask_err_d[i] = bus.req[i] && !req_seen_q[i] && (masks[i] == '0);
    end
  end

  // State register. Reset drops all ownership and clears the datapath with no flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      own_vld_q   <= '0;
      own_idx_q   <= '0;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      req_seen_q  <= '0;
      mask_err_q  <= '0;
`ifdef ARB_WATCHDOG_EN
      idle_cnt_q  <= '0;
      wd_block_q  <= '0;
      timeout_q   <= '0;
`endif
    end else begin
      own_vld_q   <= own_vld_d;
      own_idx_q   <= own_idx_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      req_seen_q  <= req_seen_d;
      mask_err_q  <= mask_err_d;
`ifdef ARB_WATCHDOG_EN
      idle_cnt_q  <= idle_cnt_d;
      wd_block_q  <= wd_block_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_busy  = own_vld_q;
  assign bus.mask_err  = mask_err_q;

endmodule

// File: doc/switch_out_arbiter.md
# switch_out_arbiter

Output-side allocator and crossbar for the 4-port packet switch. Sits directly downstream of the per-input-port controllers (IDLE/ROUTE/ARB_WAIT/TRANSMIT). Each controller raises a request carrying its destination mask while in ARB_WAIT. The block grants whole destination sets atomically with round-robin fairness, then forwards the granted input's words to the owned outputs until the request drops. Covers SDP (one target), MDP (several targets) and BDP (all targets).

## Interface
- NUM_PORTS, 4, number of input and output ports.
- DATA_WIDTH, `DATA_WIDTH (16), payload word width.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_PORTS  per-input request; held high from ARB_WAIT through end of TRANSMIT.
- req_mask  in  NUM_PORTS*NUM_PORTS  slice i = one-hot/multi-hot destination outputs of input i; stable while req[i]=1.
- in_valid  in  NUM_PORTS  per-input word valid.
- in_data  in  NUM_PORTS*DATA_WIDTH  per-input word, slice i.
- gnt  out  NUM_PORTS  registered; high while input i owns all of its requested outputs.
- out_valid  out  NUM_PORTS  per-output word valid.
- out_data  out  NUM_PORTS*DATA_WIDTH  per-output word, slice o.
- out_busy  out  NUM_PORTS  output o currently owned.
- mask_err  out  NUM_PORTS  one-cycle pulse: req[i]=1 with req_mask slice 0.
- timeout  out  NUM_PORTS  only with ARB_WATCHDOG_EN; one-cycle pulse on forced release.

## Operation
- Owner table: per output, valid bit and 2-bit owner index. Reset: all invalid. rr_ptr = 0. gnt, out_valid, out_data, out_busy, mask_err and timeout are all 0.
- Release: if owner i of output o has req[i]=0 at edge N, ownership clears at edge N. gnt[i] is 0 after edge N.
- Allocation at each edge:
  - Compute free = ~out_busy, using the registered state. Outputs freed at the same edge are not reused, so there is a minimum 1-cycle gap between owners.
  - Scan inputs i = rr_ptr, rr_ptr+1, … (mod NUM_PORTS).
  - Eligible: req[i]=1, gnt[i]=0, mask≠0, and mask ⊆ free.
  - Grant the whole mask or nothing; there are no partial grants.
  - After each grant, remove the mask from free. Several disjoint grants per cycle are allowed.
- rr_ptr ← (last input granted this cycle)+1 mod NUM_PORTS. rr_ptr is unchanged if no grant.
- Zero mask: the request is never granted. mask_err[i] pulses on the first cycle req[i] is seen, and re-arms when req drops.
- Datapath: for each owned output o with owner i, out_valid[o] ← in_valid[i] and out_data[o] ← in_data[i]. Unowned outputs: out_valid ← 0 and out_data holds its last value.
- req_mask changing while gnt=1 is ignored; the latched ownership stands.

## Timing
- req rises at edge N-1 → gnt at edge N if eligible. Minimum grant latency is 1 cycle.
- Data latency is 1 cycle: in_data sampled at edge N appears on out_data after edge N.
- Words presented before gnt is seen high are not forwarded. The upstream controller starts TRANSMIT on gnt=1.
- req and in_valid dropping in the same cycle: the last word (in_valid=1) is forwarded and ownership released at the same edge.
- rst mid-packet: all ownership is dropped, outputs go to reset values the next cycle, and no partial flush occurs.

## Configuration
- ARB_WATCHDOG_EN defined:
  - Per-input 4-bit idle counter, counting only while gnt[i]=1 and in_valid[i]=0.
  - Reaching 15 forces release of all outputs owned by i, pulses timeout[i] for 1 cycle and clears the counter.
  - gnt[i] stays 0 until req[i] falls and rises again.
  - The counter resets on any in_valid[i]=1.
- Undefined: no counters and no timeout port. Ownership is held indefinitely while req is high.

## Structure
- Add to the shared switch package:
  - `NUM_PORTS` (4).
  - typedef port_mask_t (logic [NUM_PORTS-1:0]).
  - typedef port_idx_t (2 bits).
  - Use the existing `DATA_WIDTH`.
- One combinational sub-module, rr_mask_alloc. Inputs: req, masks, free, rr_ptr. Outputs: grant vector, new ownership vectors, next rr_ptr.
- The top level holds the owner registers, crossbar registers and the optional watchdog.

## Test plan
- SDP, no contention:
  - Stimulus: req[0]=1, mask0=0b0100, then 3 words 0xA001..0xA003.
  - Response: gnt[0] after 1 cycle, out_data[2] = the same words 1 cycle later.
  - Release: req drop → out_busy[2]=0.
- Contention on one output:
  - Stimulus: inputs 1 and 3 both request mask 0b0001 from reset.
  - Response: input 1 granted first (rr_ptr=0 scan). Input 3 granted 1 cycle after input 1 releases.
  - rr_ptr then equals 0 (3+1 mod 4).
- BDP vs SDP:
  - Stimulus: input 2 owns output 1; input 0 requests 0b1111.
  - Response: input 0 waits with no partial grant. After input 2 releases, input 0 is granted and all four outputs carry its words.
- Disjoint parallel grants:
  - Stimulus: masks 0b0011 (input 0) and 0b1100 (input 1) requested in the same cycle.
  - Response: both gnt high after the same edge.
- Zero mask and reset:
  - Zero mask: req[3]=1, mask 0 → mask_err[3] single pulse, never granted.
  - Reset: rst asserted mid-transfer → all outputs 0 the next cycle.
- With ARB_WATCHDOG_EN:
  - Stimulus: granted input holds req with in_valid=0.
  - Response: timeout pulses after 15 idle cycles, out_busy clears, and no regrant until req toggles.
